// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared definitions for the memory access unit. It holds the access
//            size encodings, the FSM state enumeration, the memory_block word
//            address width and small decode helpers.
// Config   : MEM_ALIGN_CHECK_EN adds the ERR state and the alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam int MEM_ADDR_W = 18;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
`ifdef MEM_ALIGN_CHECK_EN
    ,
    ST_ERR   = 3'd4
`endif
  } state_t;

  // Both 2'b10 and the reserved 2'b11 encoding are full-word accesses.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    if (is_word(size)) return (lane != 2'b00);
    if (size == SIZE_HALF) return lane[0];
    return 1'b0;
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/mem_lane_merge.sv
// ============================================================================
// Module   : mem_lane_merge
// Purpose  : Combinational byte/half lane logic. It inserts the low store bits
//            into the selected lane of a read word (read-modify-write), and it
//            extracts the selected lane of a read word with sign/zero extension.
// Ports    : rd_word     - word returned by memory_block
//            size        - access size (byte / half / word)
//            lane        - byte address bits [1:0]
//            st_low      - low 16 bits of the store value
//            sign_ext    - 1 = sign-extend the extracted lane
//            merged_word - rd_word with the selected lane replaced
//            load_word   - right-aligned, extended load result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [15:0] st_low,
  input  logic        sign_ext,
  output logic [31:0] merged_word,
  output logic [31:0] load_word
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Half lanes ignore lane[0], so an odd half address uses the same half.
  assign byte_off = {lane, 3'b000};
  assign half_off = {lane[1], 4'b0000};

  always_comb begin
    merged_word = rd_word;
    load_word   = rd_word;
    byte_val    = rd_word[byte_off +: 8];
    half_val    = rd_word[half_off +: 16];
    case (size)
      SIZE_BYTE: begin
        merged_word[byte_off +: 8] = st_low[7:0];
        load_word = {{24{sign_ext & byte_val[7]}}, byte_val};
      end
      SIZE_HALF: begin
        merged_word[half_off +: 16] = st_low;
        load_word = {{16{sign_ext & half_val[15]}}, half_val};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store sequencer in front of a word-wide memory_block with a
//            combinational read port. Sub-word stores are done as
//            read-modify-write; sub-word loads are lane extracted and extended.
// Ports    : clk, reset (sync, active high)
//            req/isStore/size/signExt/addr/storeData - request side
//            ready, done, loadData                    - request status/result
//            memAddress, memRead, memWrite, memWriteData, memReadData
//                                                     - memory_block side
//            misaligned (only with MEM_ALIGN_CHECK_EN)
// Config   : MEM_ALIGN_CHECK_EN - misaligned half/word accesses go to ERR,
//            pulse misaligned and never touch memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  isStore,
  input  logic [1:0]            size,
  input  logic                  signExt,
  input  logic [31:0]           addr,
  input  logic [31:0]           storeData,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           loadData,
  output logic [MEM_ADDR_W-1:0] memAddress,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [31:0]           memWriteData,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  misaligned,
`endif
  input  logic [31:0]           memReadData
);

  state_t      state;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_sign;
  logic [1:0]  op_lane;
  logic [15:0] op_data;
  logic [31:0] merged_word;
  logic [31:0] load_word;

  // The address space wraps at 1 MiB; the top address bits are don't-care.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:20];

  mem_lane_merge u_lane (
    .rd_word    (memReadData),
    .size       (op_size),
    .lane       (op_lane),
    .st_low     (op_data),
    .sign_ext   (op_sign),
    .merged_word(merged_word),
    .load_word  (load_word)
  );

  // Every output is registered and updated with the state transition, so a
  // reset edge aborts the access before any strobe of the next state appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      done         <= 1'b0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      loadData     <= '0;
      op_store     <= 1'b0;
      op_size      <= SIZE_BYTE;
      op_sign      <= 1'b0;
      op_lane      <= 2'b00;
      op_data      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_store   <= isStore;
            op_size    <= size;
            op_sign    <= signExt;
            op_lane    <= addr[1:0];
            op_data    <= storeData[15:0];
            memAddress <= addr[19:2];
            ready      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            if (is_misaligned(size, addr[1:0])) begin
              state      <= ST_ERR;
              misaligned <= 1'b1;
            end else
`endif
            if (isStore && is_word(size)) begin
              // A full-word store needs no read of the old word.
              state        <= ST_WRITE;
              memWrite     <= 1'b1;
              memWriteData <= storeData;
            end else begin
              state   <= ST_READ;
              memRead <= 1'b1;
            end
          end
        end
        ST_READ: begin
          memRead <= 1'b0;
          if (op_store) begin
            state        <= ST_WRITE;
            memWrite     <= 1'b1;
            memWriteData <= merged_word;
          end else begin
            state    <= ST_DONE;
            done     <= 1'b1;
            loadData <= load_word;
          end
        end
        ST_WRITE: begin
          memWrite <= 1'b0;
          state    <= ST_DONE;
          done     <= 1'b1;
        end
        ST_DONE: begin
          // A request seen here waits for the IDLE cycle that follows.
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
`ifdef MEM_ALIGN_CHECK_EN
        ST_ERR: begin
          misaligned <= 1'b0;
          ready      <= 1'b1;
          state      <= ST_IDLE;
        end
`endif
        default: begin
          state    <= ST_IDLE;
          ready    <= 1'b1;
          done     <= 1'b0;
          memRead  <= 1'b0;
          memWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
